ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- Downstream AHB slave that consumes the decoded, muxed master-to-slave bus (select, address, control, write data).
- Implements a word-addressed SRAM with a configurable number of wait states.
- Returns ready, response and read data to the slave-to-master return mux.
- Pipelined AHB operation: the address phase of the next transfer overlaps the data phase of the current one.

Parameters:
- DEPTH, 256: number of 32-bit words; must be a power of two and ≤ 16384.
- WAIT_CYCLES, 1: H_ready-low cycles inserted in every OKAY data phase (0–15).

Ports:
- H_clk  input  1  bus clock
- H_reset  input  1  asynchronous, active-high reset
- H_sel  input  1  slave select from the address decoder
- H_write  input  1  1 = write, 0 = read (address phase)
- H_trans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- H_addr  input  32  byte address (address phase)
- H_wdata  input  32  write data (data phase)
- H_ready_in  input  1  bus-wide ready from the return mux
- H_ready  output  1  this slave's ready
- H_resp  output  2  00 OKAY, 01 ERROR
- H_rdata  output  32  read data

Behaviour:
- Clock and reset: single clock H_clk. H_reset is asynchronous, active-high.
- Reset values: H_ready=1, H_resp=00, H_rdata=0, state IDLE, wait counter=0, all captured-phase registers=0. Memory contents are not reset.
- Address-phase acceptance:
  - A transfer is accepted on a rising edge where H_sel=1, H_trans[1]=1 and H_ready_in=1.
  - IDLE and BUSY, or H_sel=0, are no transfer: no state change and the response stays OKAY.
- Captured on acceptance: write flag, word index = H_addr[15:2], error flag.
- Error flag is set if H_addr[1:0]≠0 or index ≥ DEPTH.
- States:
  - IDLE: H_ready=1, H_resp=OKAY.
    - Accept with error → ERR1.
    - Accept without error → DATA, with cnt=WAIT_CYCLES.
  - DATA: H_ready = (cnt==0), H_resp=OKAY.
    - While cnt>0, decrement cnt each cycle.
    - When cnt==0, the transfer completes this cycle.
  - Completion cycle:
    - Write: mem[index] ← H_wdata at the edge.
    - Read: H_rdata = mem[index] during the cycle.
    - Next state: a new accept without error → DATA (cnt reloaded); new accept with error → ERR1; otherwise → IDLE.
  - ERR1: H_ready=0, H_resp=ERROR → ERR2.
  - ERR2: H_ready=1, H_resp=ERROR, no memory access. Next state is chosen as in the DATA completion cycle.
- Pipelining: a new address phase is accepted only in a cycle where H_ready_in=1, which means the previous data phase has completed. No address is sampled while this slave holds H_ready=0.
- H_rdata outside a read-completion cycle: 0.
- Write data: sampled only in the completion cycle; H_wdata during wait cycles is ignored.
- Back-to-back write then read to the same address: the read returns the newly written data, with no hazard stall. This holds because the write commits at the edge that starts the read's data phase.
- With WAIT_CYCLES=0, every OKAY transfer completes in its first data-phase cycle.
- H_ready_in low while in IDLE: the address is not sampled, even with H_sel=1, because another slave is stalling.
- BUSY during a SEQ burst: no transfer; the slave stays/returns IDLE with OKAY, and the burst resumes on the following SEQ.
- Reset mid-transfer: the state machine returns to IDLE at once, a pending write is dropped, and outputs take their reset values.
- Error does not abort subsequent transfers; each transfer is evaluated independently.

Test Plan:
- Reset with H_reset=1 for 3 cycles → H_ready=1, H_resp=00, H_rdata=0. Asserting H_reset during a DATA wait cycle returns to these values asynchronously, and the pending write leaves memory unchanged.
- WAIT_CYCLES=1:
  - NONSEQ write addr 0x10, wdata 0xDEADBEEF → one H_ready=0 cycle, then H_ready=1 with OKAY.
  - Then NONSEQ read 0x10 → one wait cycle, then H_rdata=0xDEADBEEF with H_ready=1.
- WAIT_CYCLES=0: 4-beat SEQ write burst 0x20–0x2C with data 1,2,3,4, then read burst → H_ready stays 1 throughout, and reads return 1,2,3,4 in consecutive cycles.
- WAIT_CYCLES=0:
  - Write 0x40=0xA5A5A5A5 immediately followed by read 0x40 → read data phase returns 0xA5A5A5A5.
  - BUSY inserted between beats → no memory access and OKAY.
- DEPTH=256:
  - Read 0x400 (index 256) → ERR1 (ready 0, resp 01), then ERR2 (ready 1, resp 01).
  - Read 0x12 (unaligned) → same two-cycle error.
  - A following valid read of 0x10 → OKAY, correct data.
- H_sel=1 and H_trans=NONSEQ while H_ready_in=0 for 2 cycles → no acceptance and H_ready stays 1. Transfer is accepted only in the cycle H_ready_in returns to 1.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB SRAM slave with programmable wait states
module ahb_sram_slave #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        H_clk,
   input  logic        H_reset,
   input  logic        H_sel,
   input  logic        H_write,
   input  logic [1:0]  H_trans,
   input  logic [31:0] H_addr,
   input  logic [31:0] H_wdata,
   input  logic        H_ready_in,
   output logic        H_ready,
   output logic [1:0]  H_resp,
   output logic [31:0] H_rdata
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [14:0] DEPTH_W = 15'(DEPTH);
   localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);
   localparam logic [1:0]  RESP_OKAY  = 2'b00;
   localparam logic [1:0]  RESP_ERROR = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          write_q, write_d;
   logic [AW-1:0] idx_q, idx_d;

   logic [31:0]   mem [DEPTH];

   logic          accept;
   logic          addr_err;
   logic          phase_free;
   logic          done;
   logic          mem_we;
   logic          unused_bits;

   // Only the word index bits select storage; the decoder already qualified the upper address.
   assign unused_bits = ^{H_addr[31:16], H_trans[0]};

   // A transfer is taken only when the whole bus is ready, so no address is sampled while any slave stalls.
   assign accept   = H_sel & H_trans[1] & H_ready_in;
   assign addr_err = (H_addr[1:0] != 2'b00) || ({1'b0, H_addr[15:2]} >= DEPTH_W);
   assign mem_we   = done & write_q;

   // Next-state and bus outputs; a new address phase may start whenever the current data phase ends.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      idx_d      = idx_q;
      phase_free = 1'b0;
      done       = 1'b0;
      H_ready    = 1'b1;
      H_resp     = RESP_OKAY;
      H_rdata    = 32'h0;

      case (state_q)
         ST_IDLE: begin
            phase_free = 1'b1;
         end
         ST_DATA: begin
            if (cnt_q != 4'd0) begin
               H_ready = 1'b0;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               done       = 1'b1;
               phase_free = 1'b1;
               if (!write_q) begin
                  H_rdata = mem[idx_q];
               end
            end
         end
         ST_ERR1: begin
            H_ready = 1'b0;
            H_resp  = RESP_ERROR;
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            H_resp     = RESP_ERROR;
            phase_free = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (phase_free) begin
         if (accept) begin
            write_d = H_write;
            idx_d   = H_addr[AW+1:2];
            cnt_d   = WAIT_W;
            state_d = addr_err ? ST_ERR1 : ST_DATA;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // Control registers; reset abandons any transfer in flight.
   always_ff @(posedge H_clk or posedge H_reset) begin
      if (H_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         idx_q   <= idx_d;
      end
   end

   // Storage is written only in the completion cycle, so wait-cycle write data never lands.
   always_ff @(posedge H_clk) begin
      if (mem_we) begin
         mem[idx_q] <= H_wdata;
      end
   end

endmodule
